// File: rtl/pw_check.sv
// pw_check: turns held button presses into single digits, collects PW_LEN of
// them, compares against PASSWORD and reports unlock, failure or lockout.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_COLLECT | capturing digits, one per press (after release hold-off)
//   S_CHECK   | single cycle: compare full sequence against PASSWORD
//   S_OK      | password accepted; pw_ok held until clear
//   S_LOCK    | too many consecutive failures; inputs ignored until timeout
module pw_check #(
  parameter int unsigned          PW_LEN         = 4,
  parameter logic [3*PW_LEN-1:0]  PASSWORD       = 12'b001_010_011_100,
  parameter int unsigned          RELEASE_CYCLES = 1_000_000,
  parameter int unsigned          MAX_TRIES      = 3,
  parameter int unsigned          LOCK_CYCLES    = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] pwinput,
  input  logic       pw_entered,
  input  logic       clear,
  output logic       pw_ok,
  output logic       pw_fail,
  output logic       locked,
  output logic [2:0] digit_cnt,
  output logic [2:0] tries,
  output logic [2:0] TriLED
);

  localparam int unsigned SEQ_W  = 3 * PW_LEN;
  localparam int unsigned REL_W  = (RELEASE_CYCLES > 0) ? $clog2(RELEASE_CYCLES + 1) : 1;
  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {S_COLLECT, S_CHECK, S_OK, S_LOCK} state_e;

  state_e              state_q, state_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [2:0]          digit_cnt_q, digit_cnt_d;
  logic [2:0]          tries_q, tries_d;
  logic                armed_q, armed_d;
  logic [REL_W-1:0]    rel_cnt_q, rel_cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                pw_ok_q, pw_ok_d;
  logic                pw_fail_q, pw_fail_d;
  logic                locked_q, locked_d;
  logic                capture;

  assign capture = (state_q == S_COLLECT) && armed_q && pw_entered &&
                   (pwinput != 3'b000) && !clear;

  // Next-state logic: release hold-off, digit capture and the sequencing FSM
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    digit_cnt_d = digit_cnt_q;
    tries_d     = tries_q;
    armed_d     = armed_q;
    rel_cnt_d   = rel_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    pw_ok_d     = pw_ok_q;
    pw_fail_d   = 1'b0;
    locked_d    = locked_q;

    // Any held button disarms, in every state, so a press held across a state
    // change (or through a clear) must be released before it can count.
    if (pw_entered) begin
      rel_cnt_d = '0;
      if (pwinput != 3'b000) armed_d = 1'b0;
    end else if (rel_cnt_q == REL_W'(RELEASE_CYCLES)) begin
      armed_d = 1'b1;
    end else begin
      rel_cnt_d = rel_cnt_q + REL_W'(1);
      if (rel_cnt_q + REL_W'(1) == REL_W'(RELEASE_CYCLES)) armed_d = 1'b1;
    end

    case (state_q)
      S_COLLECT: begin
        if (clear) begin
          digit_cnt_d = '0;
          seq_d       = '0;
        end else if (capture) begin
          seq_d       = (seq_q << 3) | SEQ_W'(pwinput);
          digit_cnt_d = digit_cnt_q + 3'd1;
          if (digit_cnt_q + 3'd1 == 3'(PW_LEN)) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        digit_cnt_d = '0;
        seq_d       = '0;
        if (seq_q == PASSWORD) begin
          state_d = S_OK;
          pw_ok_d = 1'b1;
          tries_d = '0;
        end else begin
          pw_fail_d = 1'b1;
          if ({1'b0, tries_q} + 4'd1 < 4'(MAX_TRIES)) begin
            state_d = S_COLLECT;
            tries_d = tries_q + 3'd1;
          end else begin
            state_d    = S_LOCK;
            locked_d   = 1'b1;
            tries_d    = 3'(MAX_TRIES);
            lock_cnt_d = '0;
          end
        end
      end
      S_OK: begin
        if (clear) begin
          state_d = S_COLLECT;
          pw_ok_d = 1'b0;
        end
      end
      S_LOCK: begin
        if (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) begin
          state_d    = S_COLLECT;
          locked_d   = 1'b0;
          tries_d    = '0;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      seq_q       <= '0;
      digit_cnt_q <= '0;
      tries_q     <= '0;
      armed_q     <= 1'b1;
      rel_cnt_q   <= '0;
      lock_cnt_q  <= '0;
      pw_ok_q     <= 1'b0;
      pw_fail_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      digit_cnt_q <= digit_cnt_d;
      tries_q     <= tries_d;
      armed_q     <= armed_d;
      rel_cnt_q   <= rel_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      pw_ok_q     <= pw_ok_d;
      pw_fail_q   <= pw_fail_d;
      locked_q    <= locked_d;
    end
  end

  assign pw_ok     = pw_ok_q;
  assign pw_fail   = pw_fail_q;
  assign locked    = locked_q;
  assign digit_cnt = digit_cnt_q;
  assign tries     = tries_q;
  assign TriLED    = {digit_cnt_q != 3'd0, pw_ok_q, locked_q};

endmodule

// File: tb/tb_pw_check.sv
// Directed bench for pw_check with short release/lock timing.
module tb_pw_check;

  localparam logic [2:0] B_L = 3'd1, B_R = 3'd2, B_U = 3'd3, B_D = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] pwinput;
  logic       pw_entered;
  logic       clear;
  logic       pw_ok, pw_fail, locked;
  logic [2:0] digit_cnt, tries, TriLED;

  int vec_cnt = 0;
  int err_cnt = 0;

  pw_check #(
    .PW_LEN(4),
    .PASSWORD(12'b001_010_011_100),
    .RELEASE_CYCLES(4),
    .MAX_TRIES(3),
    .LOCK_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pwinput(pwinput), .pw_entered(pw_entered),
    .clear(clear), .pw_ok(pw_ok), .pw_fail(pw_fail), .locked(locked),
    .digit_cnt(digit_cnt), .tries(tries), .TriLED(TriLED)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] code;
    int         hold;
    int         gap;
    logic       clr;
    logic [2:0] dc;
    logic [2:0] tr;
    logic       ok;
    logic       lk;
  } vec_t;

  vec_t tbl[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [2:0] code, input int hold, input int gap);
    pwinput = code;
    pw_entered = 1'b1;
    repeat (hold) tick();
    pwinput = 3'd0;
    pw_entered = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic enter4(input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [2:0] d);
    press(a, 10, 6);
    press(b, 10, 6);
    press(c, 10, 6);
    press(d, 10, 6);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    int lk_cnt;
    int bad_dc;

    // code hold gap clr | digit_cnt tries ok locked (after the record)
    tbl[0]  = '{B_L,  10, 6, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{B_R,  10, 6, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{B_U,  10, 6, 1'b0, 3'd3, 3'd0, 1'b0, 1'b0};
    tbl[3]  = '{B_D,  10, 6, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
    tbl[4]  = '{3'd0,  1, 2, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0};
    tbl[5]  = '{B_L,  50, 2, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0};
    tbl[6]  = '{B_L,   3, 4, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0};
    tbl[7]  = '{B_R,  10, 6, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0};
    tbl[8]  = '{3'd0,  1, 2, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0};
    tbl[9]  = '{B_L,  10, 6, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0};
    tbl[10] = '{B_R,  10, 6, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0};
    tbl[11] = '{B_U,  10, 6, 1'b0, 3'd3, 3'd0, 1'b0, 1'b0};
    tbl[12] = '{B_U,  10, 6, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0};
    tbl[13] = '{B_L,  10, 6, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0};
    tbl[14] = '{B_R,  10, 6, 1'b0, 3'd2, 3'd1, 1'b0, 1'b0};
    tbl[15] = '{B_U,  10, 6, 1'b0, 3'd3, 3'd1, 1'b0, 1'b0};
    tbl[16] = '{B_D,  10, 6, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
    tbl[17] = '{3'd0,  1, 2, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    pwinput = 3'd0;
    pw_entered = 1'b0;
    clear = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("reset pw_ok", pw_ok, 0);
    chk("reset pw_fail", pw_fail, 0);
    chk("reset locked", locked, 0);
    chk("reset digit_cnt", digit_cnt, 0);
    chk("reset tries", tries, 0);
    chk("reset TriLED", TriLED, 0);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].clr) begin
        clear = 1'b1;
        repeat (tbl[i].hold) tick();
        clear = 1'b0;
        repeat (tbl[i].gap) tick();
      end else begin
        press(tbl[i].code, tbl[i].hold, tbl[i].gap);
      end
      chk($sformatf("tbl%0d digit_cnt", i), digit_cnt, tbl[i].dc);
      chk($sformatf("tbl%0d tries", i), tries, tbl[i].tr);
      chk($sformatf("tbl%0d pw_ok", i), pw_ok, tbl[i].ok);
      chk($sformatf("tbl%0d locked", i), locked, tbl[i].lk);
      chk($sformatf("tbl%0d pw_fail", i), pw_fail, 0);
      chk($sformatf("tbl%0d TriLED", i), TriLED,
          {29'd0, tbl[i].dc != 3'd0, tbl[i].ok, tbl[i].lk});
    end

    // Wrong entry: pw_fail latency and single-cycle width
    press(B_L, 10, 6);
    press(B_R, 10, 6);
    press(B_U, 10, 6);
    pwinput = B_U;
    pw_entered = 1'b1;
    tick();
    chk("fail k+1 digit_cnt", digit_cnt, 4);
    chk("fail k+1 pw_fail", pw_fail, 0);
    tick();
    chk("fail k+2 pw_fail", pw_fail, 1);
    chk("fail k+2 tries", tries, 1);
    chk("fail k+2 digit_cnt", digit_cnt, 0);
    tick();
    chk("fail k+3 pw_fail", pw_fail, 0);
    pwinput = 3'd0;
    pw_entered = 1'b0;
    repeat (6) tick();

    // Lockout after third consecutive failure
    enter4(B_L, B_R, B_U, B_U);
    chk("second fail tries", tries, 2);
    press(B_L, 10, 6);
    press(B_R, 10, 6);
    press(B_U, 10, 6);
    pwinput = B_D + 3'd1;
    pw_entered = 1'b1;
    tick();
    tick();
    chk("lock pw_fail", pw_fail, 1);
    chk("lock locked", locked, 1);
    chk("lock TriLED", TriLED, 3'b001);
    chk("lock tries", tries, 3);
    lk_cnt = 1;
    bad_dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 10) begin
        pw_entered = (i % 5) < 2;
        pwinput = pw_entered ? B_L : 3'd0;
        clear = (i == 7);
      end else begin
        pw_entered = 1'b0;
        pwinput = 3'd0;
        clear = 1'b0;
      end
      tick();
      if (locked) lk_cnt++;
      if (digit_cnt != 3'd0) bad_dc++;
    end
    chk("lock duration", lk_cnt, 20);
    chk("lock presses ignored", bad_dc, 0);
    chk("after lock locked", locked, 0);
    chk("after lock tries", tries, 0);
    enter4(B_L, B_R, B_U, B_D);
    chk("after lock pw_ok", pw_ok, 1);
    pulse_clear();
    chk("after lock clear", pw_ok, 0);

    // Clear wins over a simultaneous capture; tries is kept
    enter4(B_L, B_L, B_L, B_L);
    chk("pre-clear tries", tries, 1);
    press(B_L, 10, 6);
    press(B_R, 10, 6);
    pwinput = B_U;
    pw_entered = 1'b1;
    clear = 1'b1;
    tick();
    chk("clear+capture digit_cnt", digit_cnt, 0);
    chk("clear+capture tries", tries, 1);
    pwinput = 3'd0;
    pw_entered = 1'b0;
    clear = 1'b0;
    repeat (6) tick();
    chk("post-clear digit_cnt", digit_cnt, 0);
    enter4(B_L, B_R, B_U, B_D);
    chk("post-clear pw_ok", pw_ok, 1);
    chk("post-clear tries", tries, 0);
    pulse_clear();

    // Reset in the middle of a lockout
    enter4(B_L, B_L, B_L, B_L);
    enter4(B_L, B_L, B_L, B_L);
    enter4(B_L, B_L, B_L, B_L);
    chk("pre-reset locked", locked, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid-lock reset locked", locked, 0);
    chk("mid-lock reset tries", tries, 0);
    chk("mid-lock reset digit_cnt", digit_cnt, 0);
    chk("mid-lock reset pw_ok", pw_ok, 0);
    chk("mid-lock reset pw_fail", pw_fail, 0);
    chk("mid-lock reset TriLED", TriLED, 0);
    repeat (3) tick();
    chk("post-reset locked", locked, 0);
    enter4(B_L, B_R, B_U, B_D);
    chk("post-reset pw_ok", pw_ok, 1);
    chk("post-reset TriLED", TriLED, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pw_check.md
Name: pw_check

Overview:
- Password sequence checker placed directly downstream of the button-to-code stage.
- Consumes the 3-bit button code and its "entered" level, and turns each held press into exactly one digit using release hold-off.
- Collects PW_LEN digits, compares the full sequence against a stored password, and reports unlock or failure.
- Enforces a lockout after MAX_TRIES consecutive failures; outputs feed the parking-gate controller and the status RGB LED.

Parameters:
PW_LEN, 4, number of digits per attempt (1..7)
PASSWORD, 12'b001_010_011_100, expected sequence (L,R,U,D); first digit in the MS 3 bits; width 3*PW_LEN
RELEASE_CYCLES, 1_000_000, consecutive cycles pw_entered must be low before the next press is accepted (10 ms at 100 MHz)
MAX_TRIES, 3, consecutive failed attempts that trigger lockout (1..7)
LOCK_CYCLES, 500_000_000, lockout duration in clk cycles

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
pwinput  input  3  button code from upstream (000 none, 001 L, 010 R, 011 U, 100 D, 101 C)
pw_entered  input  1  upstream level: a button is held
clear  input  1  abort the partial entry, or leave OK state
pw_ok  output  1  level: correct password accepted
pw_fail  output  1  one-cycle pulse per failed attempt
locked  output  1  level: lockout active
digit_cnt  output  3  digits captured in the current attempt
tries  output  3  consecutive failures so far
TriLED  output  3  [0] red = locked, [1] green = pw_ok, [2] blue = digit_cnt != 0

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - state COLLECT; pw_ok, pw_fail, locked = 0; digit_cnt, tries = 0; TriLED = 000.
  - shift register 0, armed = 1, release and lock counters 0.
  - Reset takes effect mid-attempt or mid-lockout with identical results.
- Press capture, valid only in COLLECT:
  - Condition: armed=1, pw_entered=1, pwinput != 000, clear=0.
  - Action: shift pwinput into the sequence register, digit_cnt+1, armed <= 0.
  - pw_entered=1 with pwinput=000 is not a press.
- Re-arm:
  - The release counter increments each cycle pw_entered=0 and resets to 0 whenever pw_entered=1.
  - armed <= 1 when the count reaches RELEASE_CYCLES. A press held for any length yields one digit.
  - Bounces shorter than RELEASE_CYCLES yield no extra digit.
  - The counter runs in all states, so a button held across a state change must still be released before it counts.
- States:
  - COLLECT:
    - The capture of digit PW_LEN moves to CHECK on the same edge.
    - clear=1: digit_cnt <= 0 and the shift register is zeroed; tries is unchanged. clear wins over a simultaneous capture.
  - CHECK (one cycle):
    - The full sequence is compared; there is no early abort on the first wrong digit.
    - Match: go to OK; pw_ok <= 1, tries <= 0, digit_cnt <= 0.
    - Mismatch with tries+1 < MAX_TRIES: go to COLLECT; pw_fail pulses, tries+1, digit_cnt <= 0.
    - Mismatch with tries+1 == MAX_TRIES: go to LOCK; pw_fail pulses, locked <= 1, tries <= MAX_TRIES, lock counter <= 0, digit_cnt <= 0.
  - OK:
    - Presses are ignored; pw_ok is held.
    - clear=1: go to COLLECT, pw_ok <= 0.
  - LOCK:
    - Presses and clear are ignored; the lock counter increments.
    - When it reaches LOCK_CYCLES-1: go to COLLECT, locked <= 0, tries <= 0.
    - locked is therefore high for exactly LOCK_CYCLES cycles.
- Latency: if the last press is sampled in cycle k, CHECK is cycle k+1 and pw_ok or pw_fail is high from cycle k+2. pw_fail is high only in k+2.
- All outputs are registered. TriLED is a direct function of the registered outputs.
- Counter widths use $clog2 of the parameter values, with no wrap in normal use. tries saturates at MAX_TRIES.

Test Plan:
(Bench parameters: RELEASE_CYCLES=4, LOCK_CYCLES=20, MAX_TRIES=3.)
1. Correct entry: presses L,R,U,D, each held 10 cycles with 6 low cycles between -> digit_cnt steps 1..4; pw_ok=1 and TriLED=010 two cycles after the D sample; tries=0; clear -> pw_ok=0 next cycle.
2. Hold and bounce: L held 50 cycles, then low 2 cycles, then L high again, then released -> digit_cnt=1 only. After 4 low cycles, R -> digit_cnt=2.
3. Wrong entry: L,R,U,U -> pw_fail is a single-cycle pulse two cycles after the last sample; tries=1; digit_cnt=0; the next correct entry gives pw_ok=1 and tries=0.
4. Lockout: three wrong entries -> third pw_fail pulse coincides with locked=1 and TriLED=001. Presses during the lock leave digit_cnt=0. locked stays high exactly 20 cycles, then tries=0 and a correct entry is accepted.
5. Clear mid-entry: L,R, then clear asserted in the same cycle as a U capture -> digit_cnt=0, tries unchanged; a subsequent L,R,U,D gives pw_ok=1.
6. Reset mid-lock: rst_n low for 1 cycle during LOCK -> locked=0, tries=0, state COLLECT, all outputs 0 on the next cycle.
